instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/jsp_fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/instruction_fetch.sv | 97 +++++++++
 tb/tb_instruction_fetch.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/jsp_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch buffer.
package jsp_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [7:0] NOP_DEFAULT = 8'h00;

  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch buffer of fetched bytes with their addresses; flush has priority
// over push and pop so a redirect always leaves it empty.
module fetch_fifo
  import jsp_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A simultaneous pop frees the slot the push needs.
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Byte-wide instruction prefetcher: one outstanding memory read at a time, results
// buffered in fetch_fifo and presented to pipeline stage 1 from the buffer head.
module instruction_fetch
  import jsp_fetch_pkg::*;
#(
  parameter int         FIFO_DEPTH = 2,
  parameter logic [7:0] NOP_OPCODE = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  input  logic        bus_request,
  input  logic        instr_advance,
  output logic        mem_rd_req,
  output logic [15:0] mem_addr,
  input  logic        mem_rd_ack,
  input  logic [7:0]  mem_rd_data,
  output logic [7:0]  instruction,
  output logic        instr_valid,
  output logic        fetch_suppress,
  output logic [15:0] instr_pc
);

  fetch_state_t                state;
  logic [15:0]                 fetch_pc;
  logic                        fifo_push;
  logic                        fifo_pop;
  fetch_entry_t                fifo_in;
  fetch_entry_t                fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        fifo_empty;
  logic                        fifo_full;
  logic                        can_issue;

  assign mem_rd_req = (state != IDLE);
  assign fifo_pop   = instr_advance && !fifo_empty;
  assign fifo_push  = (state == REQ) && mem_rd_ack && !pc_load;
  assign fifo_in    = '{data: mem_rd_data, pc: mem_addr};
  // A pop this cycle counts as a free slot, so a full buffer restarts fetching at the pop edge.
  assign can_issue  = !bus_request && !pc_load && (!fifo_full || fifo_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      fetch_pc <= 16'h0000;
      mem_addr <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (pc_load) begin
            fetch_pc <= pc_load_value;
          end else if (can_issue) begin
            state    <= REQ;
            mem_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (pc_load) begin
            fetch_pc <= pc_load_value;
            state    <= mem_rd_ack ? IDLE : DISCARD;
          end else if (mem_rd_ack) begin
            fetch_pc <= fetch_pc + 16'd1;
            state    <= IDLE;
          end
        end
        DISCARD: begin
          // The stale read must still complete on the bus; its data is dropped.
          if (pc_load)    fetch_pc <= pc_load_value;
          if (mem_rd_ack) state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_entry(fifo_in),
    .pop       (fifo_pop),
    .flush     (pc_load),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign instr_valid    = !fifo_empty;
  assign fetch_suppress = fifo_empty;
  assign instruction    = fifo_empty ? NOP_OPCODE : fifo_head.data;
  assign instr_pc       = fifo_empty ? 16'h0000 : fifo_head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural memory and an expected-byte queue.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_value = 16'h0000;
  logic        bus_request = 1'b0;
  logic        instr_advance = 1'b0;
  logic        mem_rd_req;
  logic [15:0] mem_addr;
  logic        mem_rd_ack;
  logic [7:0]  mem_rd_data;
  logic [7:0]  instruction;
  logic        instr_valid;
  logic        fetch_suppress;
  logic [15:0] instr_pc;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          ack_total = 0;
  logic        stray_ack = 1'b0;
  logic        mon_en = 1'b0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  instruction_fetch #(
    .FIFO_DEPTH(2),
    .NOP_OPCODE(8'h00)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .bus_request   (bus_request),
    .instr_advance (instr_advance),
    .mem_rd_req    (mem_rd_req),
    .mem_addr      (mem_addr),
    .mem_rd_ack    (mem_rd_ack),
    .mem_rd_data   (mem_rd_data),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .fetch_suppress(fetch_suppress),
    .instr_pc      (instr_pc)
  );

  // Memory returns the low address byte after ack_delay wait cycles.
  assign mem_rd_ack  = (mem_rd_req && (wait_cnt >= ack_delay)) || stray_ack;
  assign mem_rd_data = stray_ack ? 8'hEE : mem_addr[7:0];

  always @(posedge clk) begin
    if (!mem_rd_req || mem_rd_ack) wait_cnt <= 0;
    else                           wait_cnt <= wait_cnt + 1;
    if (mem_rd_ack) ack_total <= ack_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One clock: sample consumed bytes at the falling edge, then move to just after the rising edge.
  task automatic step();
    logic [23:0] expected;
    @(negedge clk);
    if (mon_en && instr_valid && instr_advance) begin
      expected = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hxxxxxx;
      check("presented byte/pc", {instruction, instr_pc}, {8'h00, expected});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      step();
      cycles++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " mem_rd_req"}, mem_rd_req, 0);
    check({tag, " mem_addr"}, mem_addr, 16'h0000);
    check({tag, " instr_valid"}, instr_valid, 0);
    check({tag, " fetch_suppress"}, fetch_suppress, 1);
    check({tag, " instruction"}, instruction, 8'h00);
    check({tag, " instr_pc"}, instr_pc, 16'h0000);
  endtask

  task automatic load_pc(input logic [15:0] value);
    pc_load       = 1'b1;
    pc_load_value = value;
    step();
    pc_load       = 1'b0;
  endtask

  initial begin
    int cycles;
    int base_acks;
    int found;
    logic [15:0] first_addr;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // Streaming with zero-wait memory and continuous advance
    instr_advance = 1'b1;
    mon_en        = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back({i[7:0], i[15:0]});
    reset_n = 1'b1;
    drain("stream drain", 40, cycles);
    check("stream one byte per two cycles", (cycles <= 20), 1);

    // Full buffer stalls fetching
    mon_en        = 1'b0;
    instr_advance = 1'b0;
    load_pc(16'h0100);
    base_acks = ack_total;
    repeat (10) step();
    check("full reads issued", ack_total - base_acks, 2);
    check("full no request", mem_rd_req, 0);
    check("full head pc", instr_pc, 16'h0100);
    instr_advance = 1'b1;
    step();
    instr_advance = 1'b0;
    check("after pop request", mem_rd_req, 1);
    check("after pop addr", mem_addr, 16'h0102);
    check("after pop head pc", instr_pc, 16'h0101);

    // bus_request blocks new fetches but not an in-flight read
    bus_request = 1'b1;
    load_pc(16'h0200);
    for (int i = 0; i < 5; i++) begin
      check("bus_request blocks", mem_rd_req, 0);
      step();
    end
    ack_delay     = 3;
    bus_request   = 1'b0;
    instr_advance = 1'b1;
    mon_en        = 1'b1;
    exp_q.push_back({8'h00, 16'h0200});
    step();
    check("inflight addr", {15'd0, mem_rd_req, mem_addr}, {15'd0, 1'b1, 16'h0200});
    bus_request = 1'b1;
    drain("inflight drain", 15, cycles);
    step();
    check("inflight then blocked", mem_rd_req, 0);
    mon_en = 1'b0;

    // Redirect during an outstanding read
    load_pc(16'h0005);
    bus_request = 1'b0;
    mon_en      = 1'b1;
    exp_q.push_back({8'h34, 16'h1234});
    exp_q.push_back({8'h35, 16'h1235});
    step();
    check("redirect old addr", mem_addr, 16'h0005);
    step();
    load_pc(16'h1234);
    check("discard holds request", {15'd0, mem_rd_req, mem_addr}, {15'd0, 1'b1, 16'h0005});
    found      = 0;
    first_addr = 16'h0000;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (mem_rd_req && mem_addr != 16'h0005) begin
        found      = 1;
        first_addr = mem_addr;
      end
    end
    check("redirect new request seen", found, 1);
    check("redirect new addr", first_addr, 16'h1234);
    drain("redirect drain", 30, cycles);
    mon_en      = 1'b0;
    bus_request = 1'b1;

    // Address wrap at 16'hFFFF
    ack_delay = 0;
    load_pc(16'hFFFF);
    bus_request = 1'b0;
    mon_en      = 1'b1;
    exp_q.push_back({8'hFF, 16'hFFFF});
    exp_q.push_back({8'h00, 16'h0000});
    exp_q.push_back({8'h01, 16'h0001});
    drain("wrap drain", 30, cycles);
    mon_en = 1'b0;

    // Asynchronous reset mid-read, then a stray ack
    instr_advance = 1'b0;
    bus_request   = 1'b1;
    ack_delay     = 3;
    load_pc(16'h0300);
    bus_request = 1'b0;
    found       = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      step();
      if (instr_valid && mem_rd_req) found = 1;
    end
    check("midread setup", found, 1);
    step();
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    bus_request = 1'b1;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    stray_ack = 1'b1;
    step();
    stray_ack = 1'b0;
    step();
    check("stray ack no push", instr_valid, 0);
    check("stray ack no request", mem_rd_req, 0);
    bus_request   = 1'b0;
    ack_delay     = 0;
    instr_advance = 1'b1;
    mon_en        = 1'b1;
    exp_q.push_back({8'h00, 16'h0000});
    exp_q.push_back({8'h01, 16'h0001});
    drain("post reset drain", 20, cycles);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
